// File: rtl/f1_delay.sv
// f1_delay: random-delay timer fed by the start-lights LFSR.
// Idle: LFSR free-runs. On trigger: freeze LFSR, capture D (0 -> 1),
// count D * UNIT_TICKS tick strobes, then pulse time_out for one cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   tick       one-cycle timebase strobe
//   trigger    one-cycle start request (honoured only in IDLE)
//   abort      synchronous cancel back to IDLE, never produces time_out
//   lfsr_data  current LFSR value
//   lfsr_en    LFSR enable, high only in IDLE
//   busy       high while counting and during the DONE cycle
//   time_out   one-cycle pulse when the delay expires
//   delay_val  last captured delay D
module f1_delay #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned UNIT_TICKS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             trigger,
    input  logic             abort,
    input  logic [WIDTH-1:0] lfsr_data,
    output logic             lfsr_en,
    output logic             busy,
    output logic             time_out,
    output logic [WIDTH-1:0] delay_val
);

    localparam int unsigned PW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] remain;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] d_load;
    logic             unit_end;
    logic             unit_done;

    // Zero is never loaded: it would mean an immediate (or wrapping) delay.
    assign d_load    = (lfsr_data == '0) ? WIDTH'(1) : lfsr_data;
    assign unit_end  = (presc == PW'(UNIT_TICKS - 1));
    assign unit_done = tick && unit_end;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (unit_done && (remain == WIDTH'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    // Outputs decoded from the state register only.
    always_comb begin
        lfsr_en  = 1'b0;
        busy     = 1'b0;
        time_out = 1'b0;
        case (state)
            IDLE: begin
                lfsr_en = 1'b1;
            end
            COUNT: begin
                busy = 1'b1;
            end
            DONE: begin
                busy     = 1'b1;
                time_out = 1'b1;
            end
            default: begin
                lfsr_en = 1'b1;
            end
        endcase
    end

    // Delay capture, prescaler and remaining-unit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain    <= '0;
            presc     <= '0;
            delay_val <= '0;
        end else if (abort) begin
            remain <= '0;
            presc  <= '0;
        end else if ((state == IDLE) && trigger) begin
            delay_val <= d_load;
            remain    <= d_load;
            presc     <= '0;
        end else if ((state == COUNT) && tick) begin
            if (unit_end) begin
                presc  <= '0;
                remain <= remain - WIDTH'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule
